// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: LFSR random-value server with 2-way round-robin grant; `LFSR_LOCKUP_GUARD_EN enables zero lock-up handling
module lfsr_rr_sched #(
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] Qout,
  output logic             rnd_vld,
  output logic             busy,
  output logic             wrap
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] q, shadow, nxt, seed_eff;
  logic last, fire, pick;
  assign nxt = {q[WIDTH-2:0], ^(q & TAPS)};
  assign fire = (state == RUN) && !stop && |req;
  // last holds the index granted most recently; a tie goes to the other one
  assign pick = &req ? ~last : req[1];
  assign busy = (state == RUN);
`ifdef LFSR_LOCKUP_GUARD_EN
  assign seed_eff = |seed ? seed : WIDTH'(1);
`else
  assign seed_eff = seed;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q       <= WIDTH'(1);
      shadow  <= WIDTH'(1);
      gnt     <= '0;
      Qout    <= '0;
      rnd_vld <= 1'b0;
      wrap    <= 1'b0;
      last    <= 1'b1;
    end else begin
      gnt     <= fire ? (pick ? 2'b10 : 2'b01) : 2'b00;
      rnd_vld <= fire;
      wrap    <= fire && (nxt == shadow);
      if (fire) begin
        Qout <= q;
        last <= pick;
      end
      if (state == IDLE) begin
        state <= (start && !stop) ? RUN : IDLE;
        if (seed_load) begin
          q      <= seed_eff;
          shadow <= seed_eff;
        end
      end else begin
        if (stop) state <= IDLE;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (q == '0) q <= WIDTH'(1);
        else if (fire) q <= nxt;
`else
        if (fire) q <= nxt;
`endif
      end
    end
  end
endmodule
